// File: rtl/ins_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and buffer depth.
package ins_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } fetch_state_e;

   localparam int FETCH_BUF_DEPTH = 2;

endpackage

// File: rtl/ins_fetch_buf.sv
// Two-entry FIFO of {instruction, pc} that absorbs the memory read latency.
module fetch_buf
   import ins_fetch_pkg::*;
#(
   parameter int DATA_W = 9,
   parameter int PC_W   = 8
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [PC_W-1:0]   pc_i,
   output logic [DATA_W-1:0] data_o,
   output logic [PC_W-1:0]   pc_o,
   output logic [1:0]        count_o
);

   localparam logic [1:0] DEPTH_C = 2'(FETCH_BUF_DEPTH);

   logic [DATA_W-1:0] data_q [FETCH_BUF_DEPTH];
   logic [PC_W-1:0]   pc_q   [FETCH_BUF_DEPTH];
   logic              rd_ptr_q;
   logic              wr_ptr_q;
   logic [1:0]        count_q;
   logic              do_pop;
   logic              do_push;

   assign do_pop  = pop_i & (count_q != 2'd0);
   // A full buffer may still accept a push when the head leaves in the same cycle.
   assign do_push = push_i & ((count_q != DEPTH_C) | do_pop);

   always_ff @(posedge clk) begin
      if (!rstN) begin
         for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            data_q[wr_ptr_q] <= data_i;
            pc_q[wr_ptr_q]   <= pc_i;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + 2'(do_push) - 2'(do_pop);
      end
   end

   assign data_o  = data_q[rd_ptr_q];
   assign pc_o    = pc_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: PC, issue control and run/stop FSM feeding decode through fetch_buf.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start
// ST_FETCH | issuing reads and delivering instructions
// ST_DONE  | program ended, waiting for a restart
module ins_fetch
   import ins_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    INS_WIDTH  = 9,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  start,
   input  logic                  end_op,
   input  logic                  jump_en,
   input  logic [ADDR_WIDTH-1:0] jump_addr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rEn,
   input  logic [INS_WIDTH-1:0]  mem_ins,
   output logic [INS_WIDTH-1:0]  ins_out,
   output logic [ADDR_WIDTH-1:0] ins_pc,
   output logic                  ins_valid,
   input  logic                  ins_ready,
   output logic                  done
);

   fetch_state_e          state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] resp_pc_q;
   logic                  inflight_q;

   logic                  in_fetch;
   logic [1:0]            count;
   logic                  pop;
   logic [2:0]            occupancy;
   logic                  issue;
   logic                  flush;
   logic                  push;

   assign in_fetch  = (state_q == ST_FETCH);
   assign ins_valid = in_fetch & (count != 2'd0);
   assign pop       = ins_valid & ins_ready;

   // Reserve a buffer slot for every read in flight so the FIFO can never overflow.
   assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = in_fetch & ~jump_en & ~end_op & (occupancy < 3'd2);
   assign flush     = in_fetch & (jump_en | end_op);
   assign push      = inflight_q & ~flush;

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q    <= ST_IDLE;
         pc_q       <= START_ADDR;
         resp_pc_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            resp_pc_q <= pc_q;
            pc_q      <= pc_q + 1'b1;
         end
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q <= ST_FETCH;
                  pc_q    <= START_ADDR;
               end
            end
            ST_FETCH: begin
               if (end_op) begin
                  state_q <= ST_DONE;
               end else if (jump_en) begin
                  pc_q <= jump_addr;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   fetch_buf #(
      .DATA_W (INS_WIDTH),
      .PC_W   (ADDR_WIDTH)
   ) u_buf (
      .clk     (clk),
      .rstN    (rstN),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .data_i  (mem_ins),
      .pc_i    (resp_pc_q),
      .data_o  (ins_out),
      .pc_o    (ins_pc),
      .count_o (count)
   );

   assign mem_addr = pc_q;
   assign mem_rEn  = issue;
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_ins_fetch.sv
// Directed-vector bench for ins_fetch with a 1-cycle memory returning {1'b1, addr}.
module tb_ins_fetch;

   logic       clk;
   logic       rstN;
   logic       start;
   logic       end_op;
   logic       jump_en;
   logic [7:0] jump_addr;
   logic [7:0] mem_addr;
   logic       mem_rEn;
   logic [8:0] mem_ins;
   logic [8:0] ins_out;
   logic [7:0] ins_pc;
   logic       ins_valid;
   logic       ins_ready;
   logic       done;

   int checks   = 0;
   int failures = 0;

   ins_fetch #(
      .ADDR_WIDTH (8),
      .INS_WIDTH  (9),
      .START_ADDR (8'h00)
   ) dut (
      .clk       (clk),
      .rstN      (rstN),
      .start     (start),
      .end_op    (end_op),
      .jump_en   (jump_en),
      .jump_addr (jump_addr),
      .mem_addr  (mem_addr),
      .mem_rEn   (mem_rEn),
      .mem_ins   (mem_ins),
      .ins_out   (ins_out),
      .ins_pc    (ins_pc),
      .ins_valid (ins_valid),
      .ins_ready (ins_ready),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial mem_ins = 9'h000;
   always @(posedge clk) begin
      if (mem_rEn) mem_ins <= {1'b1, mem_addr};
   end

   typedef struct packed {
      logic       rst_n;
      logic       st;
      logic       eo;
      logic       je;
      logic [7:0] ja;
      logic       rdy;
      logic [7:0] e_addr;
      logic       e_ren;
      logic       e_valid;
      logic [7:0] e_pc;
      logic       e_done;
      logic       hz;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst_n, input logic st, input logic eo, input logic je,
                      input logic [7:0] ja, input logic rdy, input logic [7:0] e_addr,
                      input logic e_ren, input logic e_valid, input logic [7:0] e_pc,
                      input logic e_done, input logic hz);
      vec_t v;
      v.rst_n = rst_n; v.st = st; v.eo = eo; v.je = je; v.ja = ja; v.rdy = rdy;
      v.e_addr = e_addr; v.e_ren = e_ren; v.e_valid = e_valid; v.e_pc = e_pc;
      v.e_done = e_done; v.hz = hz;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h exp=%0h", name, idx, got, exp);
      end
   endtask

   initial begin
      logic [8:0] e_ins;
      logic [7:0] exp_pc;
      int         lat;
      bit         found;

      rstN = 1'b0; start = 1'b0; end_op = 1'b0; jump_en = 1'b0;
      jump_addr = 8'h00; ins_ready = 1'b0;

      //  rst st eo je ja     rdy addr   ren val pc     dn hz
      add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1);   // reset state
      add(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0);   // start
      add(1, 0, 0, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h01, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h02, 1, 1, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h03, 1, 1, 8'h01, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h04, 1, 1, 8'h02, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h05, 1, 1, 8'h03, 0, 0);
      add(1, 0, 0, 0, 8'h00, 0, 8'h06, 0, 1, 8'h04, 0, 0);   // stall
      add(1, 0, 0, 0, 8'h00, 0, 8'h06, 0, 1, 8'h04, 0, 0);
      add(1, 0, 0, 0, 8'h00, 0, 8'h06, 0, 1, 8'h04, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h06, 1, 1, 8'h04, 0, 0);   // release
      add(1, 0, 0, 0, 8'h00, 1, 8'h07, 1, 1, 8'h05, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h08, 1, 1, 8'h06, 0, 0);
      add(1, 0, 0, 0, 8'h00, 0, 8'h09, 0, 1, 8'h07, 0, 0);   // fill to 2
      add(1, 0, 0, 1, 8'h40, 1, 8'h09, 0, 1, 8'h07, 0, 0);   // jump 0x40
      add(1, 0, 0, 0, 8'h00, 1, 8'h40, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h41, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h42, 1, 1, 8'h40, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h43, 1, 1, 8'h41, 0, 0);
      add(1, 0, 0, 1, 8'hFE, 1, 8'h44, 0, 1, 8'h42, 0, 0);   // jump 0xFE
      add(1, 0, 0, 0, 8'h00, 1, 8'hFE, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'hFF, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h00, 1, 1, 8'hFE, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h01, 1, 1, 8'hFF, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h02, 1, 1, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h03, 1, 1, 8'h01, 0, 0);
      add(1, 0, 1, 1, 8'h77, 1, 8'h04, 0, 1, 8'h02, 0, 0);   // end_op beats jump
      add(1, 0, 0, 0, 8'h00, 1, 8'h04, 0, 0, 8'h00, 1, 0);
      add(1, 0, 0, 1, 8'h55, 1, 8'h04, 0, 0, 8'h00, 1, 0);   // jump ignored in DONE
      add(1, 0, 0, 0, 8'h00, 1, 8'h04, 0, 0, 8'h00, 1, 0);
      add(1, 1, 0, 0, 8'h00, 1, 8'h04, 0, 0, 8'h00, 1, 0);   // restart
      add(1, 0, 0, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h01, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h02, 1, 1, 8'h00, 0, 0);
      add(1, 1, 0, 0, 8'h00, 1, 8'h03, 1, 1, 8'h01, 0, 0);   // start ignored in FETCH
      add(1, 0, 0, 0, 8'h00, 1, 8'h04, 1, 1, 8'h02, 0, 0);
      add(0, 0, 0, 0, 8'h00, 1, 8'h05, 1, 1, 8'h03, 0, 0);   // reset mid-stream
      add(1, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 1);
      add(1, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 1);
      add(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h01, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'h02, 1, 1, 8'h00, 0, 0);

      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         rstN      = vecs[i].rst_n;
         start     = vecs[i].st;
         end_op    = vecs[i].eo;
         jump_en   = vecs[i].je;
         jump_addr = vecs[i].ja;
         ins_ready = vecs[i].rdy;
         @(negedge clk);
         chk("mem_addr", i, 32'(mem_addr), 32'(vecs[i].e_addr));
         chk("mem_rEn", i, 32'(mem_rEn), 32'(vecs[i].e_ren));
         chk("ins_valid", i, 32'(ins_valid), 32'(vecs[i].e_valid));
         chk("done", i, 32'(done), 32'(vecs[i].e_done));
         if (vecs[i].e_valid || vecs[i].hz) begin
            e_ins = vecs[i].e_valid ? {1'b1, vecs[i].e_pc} : 9'h000;
            chk("ins_pc", i, 32'(ins_pc), 32'(vecs[i].e_pc));
            chk("ins_out", i, 32'(ins_out), 32'(e_ins));
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0; jump_en = 1'b0; end_op = 1'b0; rstN = 1'b1;

      // Stop, restart, and measure edges from the start edge to ins_valid.
      end_op = 1'b1;
      @(posedge clk); #1;
      end_op = 1'b0;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      lat    = 0;
      found  = 1'b0;
      while (!found && lat < 10) begin
         @(negedge clk);
         if (ins_valid) found = 1'b1;
         else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      chk("start_latency", 0, 32'(lat), 32'd2);

      // Stream with ready high for 8 cycles, then random backpressure; order must be exact.
      exp_pc = 8'h00;
      for (int i = 0; i < 40; i++) begin
         if (i < 8) chk("stream_gapless", i, 32'(ins_valid), 32'd1);
         if (ins_valid) begin
            chk("stream_pc", i, 32'(ins_pc), 32'(exp_pc));
            chk("stream_ins", i, 32'(ins_out), 32'({1'b1, exp_pc}));
            if (ins_ready) exp_pc = exp_pc + 8'h01;
         end
         @(posedge clk); #1;
         ins_ready = (i + 1 < 8) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      chk("stream_progress", 0, 32'(exp_pc > 8'd12), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
Per-core instruction fetch unit: the requester side of the core's synchronous instruction memory port (address plus read-enable in, registered instruction out one cycle later). It holds the PC, issues reads, absorbs the memory's 1-cycle read latency in a 2-entry buffer, and presents instructions to decode over a valid/ready handshake. It also handles jump redirects (flushing stale fetches) and start/end-of-program control.

Parameters:
ADDR_WIDTH, 8, PC / memory address width; PC wraps modulo 2**ADDR_WIDTH.
INS_WIDTH, 9, instruction word width.
START_ADDR, 0, PC value loaded on reset and on start.

Ports:
clk  in  1  core clock, all state on rising edge
rstN  in  1  synchronous active-low reset
start  in  1  pulse; IDLE/DONE -> FETCH, PC <= START_ADDR
end_op  in  1  program finished; stop fetching, flush, enter DONE
jump_en  in  1  redirect request, valid in FETCH only
jump_addr  in  ADDR_WIDTH  redirect target
mem_addr  out  ADDR_WIDTH  to memory address input (= PC register)
mem_rEn  out  1  to memory read enable (combinational, see below)
mem_ins  in  INS_WIDTH  from memory data out, valid the cycle after mem_rEn=1
ins_out  out  INS_WIDTH  buffered instruction at head
ins_pc  out  ADDR_WIDTH  address of ins_out
ins_valid  out  1  buffer non-empty
ins_ready  in  1  decode accepts head; transfer = ins_valid & ins_ready
done  out  1  high in DONE

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low on rstN, sampled on the rising edge.
- Reset values: state=IDLE, PC=START_ADDR, buffer count=0, inflight=0, mem_rEn=0, ins_valid=0, ins_out=0, ins_pc=0, done=0.
- Reset mid-operation: all state is cleared. A memory response arriving in the cycle after reset is ignored.
- States:
  - IDLE: start -> FETCH.
  - FETCH: end_op -> DONE, which has priority over jump_en.
  - DONE: start -> FETCH.
  - start is ignored in FETCH.
- pop = ins_valid & ins_ready.
- Issue: mem_rEn = (state==FETCH) & ~jump_en & ~end_op & ((count + inflight - pop) < 2).
- On issue:
  - PC <= PC + 1, with 2**ADDR_WIDTH-1 wrapping to 0.
  - inflight <= 1, and the issuing address is recorded as resp_pc.
  - Otherwise inflight <= 0.
- Response capture: if inflight=1 and no flush this cycle, {mem_ins, resp_pc} is pushed into the buffer at the edge.
- Invariant: count + inflight <= 2. The buffer never overflows.
- Buffer: 2-entry FIFO; head drives ins_out/ins_pc. Push and pop in the same cycle are both honoured. Head outputs are stable while ins_valid & ~ins_ready.
- Latency: the edge sampling start puts START_ADDR on mem_addr with mem_rEn=1. ins_valid rises after the 2nd following edge.
- Throughput: with ins_ready held high, one instruction per cycle is sustained.
- Jump (FETCH, jump_en=1):
  - No issue that cycle. PC <= jump_addr; the first read of jump_addr occurs the next cycle.
  - Buffer count <= 0 and inflight <= 0, so the pending response is discarded.
  - A pop in the same cycle still completes; decode owns that word. All other buffered words are discarded.
  - jump_en outside FETCH is ignored.
- end_op: same flush as a jump. PC is held; state -> DONE, done=1, mem_rEn=0. A same-cycle pop still completes.
- Outside FETCH: mem_rEn=0 and ins_valid=0.
- Width rules: PC arithmetic is unsigned ADDR_WIDTH with no carry out. count is 2 bits.

Decomposition:
- Shared package ins_fetch_pkg: state encoding (IDLE=2'd0, FETCH=2'd1, DONE=2'd2) and FETCH_BUF_DEPTH=2.
- One sub-module, fetch_buf: a 2-entry FIFO of {INS_WIDTH data, ADDR_WIDTH pc} with push, pop, flush, count, and head outputs.
- PC, FSM and issue logic stay in ins_fetch.

Test Plan:
All scenarios use a behavioural 1-cycle-latency memory model with mem[a] = {1'b1, a}.
1. Reset, then start with ins_ready=1 for 10 cycles -> ins_valid rises 2 edges after start. ins_pc = 0,1,2,...,7 on consecutive cycles with ins_out = 0x100..0x107. No gaps.
2. ins_ready=0 from cycle 3 for 5 cycles -> mem_rEn drops once count+inflight=2. ins_out/ins_pc are held. After release, the sequence resumes with no loss or duplication.
3. jump_en with jump_addr=0x40 while the buffer holds 2 entries and ins_ready=1 -> the head popped that cycle is delivered. The next delivered ins_pc is 0x40 (ins_out 0x140) with no stale PCs, and mem_addr=0x40 with mem_rEn=1 on the cycle after the jump.
4. jump_addr=0xFE, ready high -> ins_pc sequence 0xFE, 0xFF, 0x00, 0x01 (wrap).
5. end_op mid-stream -> done=1 the next cycle, mem_rEn=0, and ins_valid falls. A later start restarts at START_ADDR with ins_pc=0 first.
6. rstN=0 for one cycle while inflight=1 with 1 buffered entry -> all outputs return to reset values. No word is delivered until a new start.
